// File: rtl/arb_mux_n_if.sv
// arb_mux_n_if: bundle of the N input streams and the single output stream of arb_mux_n.
//   in_valid/in_ready/in_data/in_last : N producer channels, channel i data at in_data[i*W +: W]
//   out_valid/out_ready/out_data/out_last/out_sel : registered consumer stream
// Modports: master = producer/consumer side (testbench or surrounding logic), slave = the mux.
interface arb_mux_n_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
);
  localparam int unsigned SelW = $clog2(N);

  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_last;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic [SelW-1:0] out_sel;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_last,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last,
    input  out_sel
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_last,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last,
    output out_sel
  );
endinterface

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel, W-bit round-robin arbitrating mux with one output register stage.
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus_io : arb_mux_n_if.slave
//            in_valid/in_ready/in_data/in_last - per-channel producer handshake
//            out_valid/out_ready/out_data/out_last/out_sel - registered output beat
// With LOCK=1 the grant stays on one channel from the first beat of a packet until the beat
// flagged last has been transferred; with LOCK=0 every beat is arbitrated independently.
module arb_mux_n #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 32,
  parameter int unsigned LOCK = 1
) (
  input logic         clk,
  input logic         rst_n,
  arb_mux_n_if.slave  bus_io
);

  localparam int unsigned SelW = $clog2(N);

  localparam logic [0:0] StArb    = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  if (N < 2 || (N & (N - 1)) != 0) begin : g_param_err
    $error("arb_mux_n: N must be a power of two and at least 2");
  end

  // Local copies of the interface signals.
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic           out_ready;
  logic [N-1:0]   in_ready;

  assign in_valid  = bus_io.in_valid;
  assign in_last   = bus_io.in_last;
  assign in_data   = bus_io.in_data;
  assign out_ready = bus_io.out_ready;

  // State.
  logic [0:0]      state_q, state_d;
  logic [SelW-1:0] lock_ch_q, lock_ch_d;
  logic [SelW-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [SelW-1:0] out_sel_q, out_sel_d;

  // Arbitration results.
  logic [SelW-1:0] gnt;
  logic            gnt_vld;
  logic [SelW-1:0] scan_idx;
  logic [W-1:0]    gnt_data;
  logic            gnt_last;
  logic            accept;
  logic            xfer;

  // Grant: fixed channel while locked, otherwise first valid channel scanning from ptr.
  // N is a power of two, so the modulo wrap is plain truncation of ptr + k.
  always_comb begin
    gnt      = '0;
    gnt_vld  = 1'b0;
    scan_idx = '0;
    if (state_q == StLocked) begin
      gnt     = lock_ch_q;
      gnt_vld = in_valid[lock_ch_q];
    end else begin
      for (int k = 0; k < N; k++) begin
        scan_idx = ptr_q + SelW'(k);
        if (!gnt_vld && in_valid[scan_idx]) begin
          gnt_vld = 1'b1;
          gnt     = scan_idx;
        end
      end
    end
  end

  // Select the granted channel's payload.
  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SelW'(i)) begin
        gnt_data = in_data[i*W +: W];
        gnt_last = in_last[i];
      end
    end
  end

  // The register can load when empty or being drained this cycle. Gating with rst_n keeps
  // in_ready low while reset is asserted, since out_valid_q alone would allow a load.
  assign accept = rst_n & (~out_valid_q | out_ready);
  assign xfer   = gnt_vld & accept;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[gnt] = 1'b1;
    end
  end

  // Output register: a new transfer overwrites a beat being drained in the same cycle.
  always_comb begin
    out_valid_d = xfer | (out_valid_q & ~out_ready);
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_data_d = gnt_data;
      out_last_d = gnt_last;
      out_sel_d  = gnt;
    end
  end

  // Round-robin pointer moves past the winner only at packet boundaries (every beat if
  // LOCK=0), so a locked packet does not skew fairness.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && (gnt_last || LOCK == 0)) begin
      ptr_d = gnt + 1'b1;
    end
  end

  // Packet lock FSM; never leaves StArb when LOCK=0.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    if (LOCK != 0 && xfer) begin
      case (state_q)
        StArb: begin
          if (!gnt_last) begin
            state_d   = StLocked;
            lock_ch_d = gnt;
          end
        end
        StLocked: begin
          if (gnt_last) begin
            state_d = StArb;
          end
        end
        default: begin
          state_d = StArb;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StArb;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_last  = out_last_q;
  assign bus_io.out_sel   = out_sel_q;

endmodule
